game_ctrl: RTL and testbench
============================

# game_ctrl

Blackjack game-flow controller that sequences the click datapath and the card source. It takes the level-valued `deal`/`hit`/`stand` click outputs and converts each press into exactly one game action. It drives a request/acknowledge handshake to the card source and accumulates the player and dealer hands. It publishes the game state, totals and result to the button/text renderers.

## Interface
Parameters:
- `DEALER_STAND`, 17: dealer draws while best total < this value; stands on soft 17.
- `BJ_LIMIT`, 21: bust threshold.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `deal`  in  1  level from click decoder; high while DEAL button is held.
- `hit`  in  1  level; HIT button held.
- `stand`  in  1  level; STAND button held.
- `card_req`  out  1  request one card from the card source.
- `card_ack`  in  1  card source presents `card_value`; one-cycle pulse.
- `card_value`  in  4  1 = ace, 2..10 = pip/face value.
- `card_to_dealer`  out  1  destination of the pending request: 0 = player, 1 = dealer.
- `state`  out  3  `game_state_t`, drives which buttons are drawn.
- `player_total`  out  5  best player total.
- `dealer_total`  out  5  best dealer total.
- `player_cards`  out  4  cards in player hand, saturating at 15.
- `dealer_cards`  out  4  cards in dealer hand, saturating at 15.
- `result`  out  2  `result_t`: NONE = 0, PLAYER_WIN = 1, DEALER_WIN = 2, PUSH = 3.

## Operation
Click edge detection:
- `deal`, `hit` and `stand` are registered once. An action fires on a 0→1 transition only.
- Holding a button never repeats the action.
- Priority on simultaneous edges: deal > hit > stand.

Action gating:
- `deal` is accepted only in IDLE or RESULT.
- `hit` and `stand` are accepted only in PLAYER.
- All other edges are dropped silently.

States:
- IDLE: all hands clear, `result` = NONE. A deal edge → DEAL.
- DEAL: clears both hands and `result`, then requests 4 cards in the order player, dealer, player, dealer (2-bit counter). After the 4th ack: player total = 21 → DEALER; otherwise → PLAYER.
- PLAYER:
  - hit edge → DRAW_P.
  - stand edge → DEALER.
- DRAW_P: one card to the player. After the ack:
  - total > BJ_LIMIT → RESULT with DEALER_WIN.
  - total = 21 → DEALER.
  - otherwise → PLAYER.
- DEALER:
  - dealer best total < DEALER_STAND → request a card to the dealer and re-evaluate after the ack.
  - otherwise → RESULT.
- RESULT:
  - Outcome, evaluated in this order: dealer > 21 → PLAYER_WIN; player > dealer → PLAYER_WIN; player < dealer → DEALER_WIN; equal → PUSH.
  - `result` holds until the next accepted deal edge, which → DEAL.

Hand arithmetic (per hand):
- Keep a 5-bit hard sum (ace counted as 1) and an `has_ace` flag.
- Best total = hard + 10 if `has_ace` and hard ≤ 11; otherwise best total = hard.
- Maximum hard sum is 31, so it fits in 5 bits and never wraps.
- `card_value` 0 or 11..15 is treated as 10.

Handshake:
- `card_req` rises and is held until the cycle `card_ack` is high. `card_value` is sampled in that cycle.
- `card_req` is low the following cycle for at least one cycle before any further request.
- `card_to_dealer` is stable whenever `card_req` is high.
- `card_ack` while `card_req` is low is ignored.
- Clicks arriving while a request is outstanding are dropped, not queued.

## Timing
- Reset (async): `state` = IDLE, `card_req` = 0, `card_to_dealer` = 0, totals = 0, card counts = 0, `result` = NONE, edge registers = 0. Outputs are cleared immediately, mid-handshake included; a pending ack is discarded.
- Deal latency: `deal` high in cycle N (low in N−1) → `state` = DEAL and `card_req` = 1 in N+1.
- Ack in cycle M → hand updated in M+1 → next `card_req` no earlier than M+2.
- A dealer standing decision takes one cycle after the totals update.
- All outputs are registered.

## Structure
- `blackjack_pkg`:
  - `game_state_t` = {IDLE, DEAL, PLAYER, DRAW_P, DEALER, RESULT}
  - `result_t`
  - `CARD_W` = 4, `TOTAL_W` = 5
- Sub-module `hand_acc`, instantiated twice (player and dealer):
  - Inputs: `clk`, `rst`, `clear`, `add`, `card_value`.
  - Outputs: best total, card count.

## Test plan
- Reset, press `deal` held for 1000 cycles; source acks 10, 5, 7, 9 → exactly 4 requests; player = 17, dealer = 14, `state` = PLAYER; no second deal.
- Player 10 + 6, hit acks 9 → player = 25, `result` = DEALER_WIN, `state` = RESULT, no dealer draw.
- Dealer ace + 6 (soft 17) after player stands on 18 → dealer draws nothing; `result` = PLAYER_WIN. Dealer ace + 5 draws; ack 10 → dealer = 16 → draws again.
- Initial deal player ace + 10 → `state` skips PLAYER straight to DEALER. Dealer reaches 21 → `result` = PUSH.
- Clicks during an outstanding `card_req` (hit/stand), plus simultaneous deal and hit edges in RESULT → no effect except the deal edge starting DEAL.
- Assert `rst` while `card_req` = 1 and ack coincident → all outputs at reset values in the same cycle; a later deal restarts cleanly with the counter at 0.

Source files
------------

// File: rtl/blackjack_pkg.sv
// rtl/blackjack_pkg.sv - shared types, widths and scoring helpers for the blackjack controller
package blackjack_pkg;

  localparam int CARD_W  = 4;
  localparam int TOTAL_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DEAL   = 3'd1,
    ST_PLAYER = 3'd2,
    ST_DRAW_P = 3'd3,
    ST_DEALER = 3'd4,
    ST_RESULT = 3'd5
  } game_state_t;

  typedef enum logic [1:0] {
    RES_NONE       = 2'd0,
    RES_PLAYER_WIN = 2'd1,
    RES_DEALER_WIN = 2'd2,
    RES_PUSH       = 2'd3
  } result_t;

  // Hard points of one card: ace scores 1, faces and unused codes score 10.
  function automatic logic [TOTAL_W-1:0] card_points(input logic [CARD_W-1:0] v);
    if (v == 4'd0 || v > 4'd10) begin
      card_points = 5'd10;
    end else begin
      card_points = {1'b0, v};
    end
  endfunction

  // One ace may count 11 whenever that does not bust the hand.
  function automatic logic [TOTAL_W-1:0] best_total(input logic [TOTAL_W-1:0] hard,
                                                    input logic               has_ace);
    if (has_ace && hard <= 5'd11) begin
      best_total = hard + 5'd10;
    end else begin
      best_total = hard;
    end
  endfunction

  // Final outcome once the dealer has finished drawing; dealer bust is checked first.
  function automatic result_t judge(input logic [TOTAL_W-1:0] player,
                                    input logic [TOTAL_W-1:0] dealer,
                                    input logic [TOTAL_W-1:0] limit);
    if (dealer > limit) begin
      judge = RES_PLAYER_WIN;
    end else if (player > dealer) begin
      judge = RES_PLAYER_WIN;
    end else if (player < dealer) begin
      judge = RES_DEALER_WIN;
    end else begin
      judge = RES_PUSH;
    end
  endfunction

endpackage

// File: rtl/hand_acc.sv
// rtl/hand_acc.sv - one blackjack hand: hard sum, ace flag, best total and card count
module hand_acc
  import blackjack_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               add,
  input  logic [CARD_W-1:0]  card_value,
  output logic [TOTAL_W-1:0] total,
  output logic [3:0]         cards
);

  logic [TOTAL_W-1:0] hard_q, hard_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic               has_ace_q, has_ace_d;
  logic [3:0]         cards_q, cards_d;
  logic [TOTAL_W:0]   sum_wide;

  // Next hand contents; the best total is registered alongside the hard sum.
  always_comb begin
    hard_d    = hard_q;
    has_ace_d = has_ace_q;
    cards_d   = cards_q;
    sum_wide  = {1'b0, hard_q} + {1'b0, card_points(card_value)};
    if (clear) begin
      hard_d    = '0;
      has_ace_d = 1'b0;
      cards_d   = '0;
    end else if (add) begin
      hard_d = sum_wide[TOTAL_W] ? '1 : sum_wide[TOTAL_W-1:0];
      if (card_value == 4'd1) begin
        has_ace_d = 1'b1;
      end
      if (cards_q != 4'hF) begin
        cards_d = cards_q + 4'd1;
      end
    end
    total_d = best_total(hard_d, has_ace_d);
  end

  // Hand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hard_q    <= '0;
      has_ace_q <= 1'b0;
      cards_q   <= '0;
      total_q   <= '0;
    end else begin
      hard_q    <= hard_d;
      has_ace_q <= has_ace_d;
      cards_q   <= cards_d;
      total_q   <= total_d;
    end
  end

  assign total = total_q;
  assign cards = cards_q;

endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - blackjack game flow: click edges, card request handshake, hands and result
module game_ctrl
  import blackjack_pkg::*;
#(
  parameter int DEALER_STAND = 17,
  parameter int BJ_LIMIT     = 21
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       deal,
  input  logic       hit,
  input  logic       stand,
  output logic       card_req,
  input  logic       card_ack,
  input  logic [3:0] card_value,
  output logic       card_to_dealer,
  output logic [2:0] state,
  output logic [4:0] player_total,
  output logic [4:0] dealer_total,
  output logic [3:0] player_cards,
  output logic [3:0] dealer_cards,
  output logic [1:0] result
);

  localparam logic [TOTAL_W-1:0] STAND_T = TOTAL_W'(DEALER_STAND);
  localparam logic [TOTAL_W-1:0] LIMIT_T = TOTAL_W'(BJ_LIMIT);

  logic [2:0]         btn_q, btn_d;
  logic               deal_edge, hit_edge, stand_edge;
  logic               act_deal, act_hit, act_stand;

  game_state_t        state_q, state_d;
  result_t            result_q, result_d;
  logic               req_q, req_d;
  logic               to_dealer_q, to_dealer_d;
  logic [1:0]         cnt_q, cnt_d;

  logic               hands_clear;
  logic               ack_ok, p_add, d_add;
  logic [TOTAL_W-1:0] p_total, d_total;
  logic [3:0]         p_cards, d_cards;

  // Rising-edge detection on the button levels; deal beats hit beats stand.
  always_comb begin
    btn_d      = {deal, hit, stand};
    deal_edge  = deal  & ~btn_q[2];
    hit_edge   = hit   & ~btn_q[1];
    stand_edge = stand & ~btn_q[0];
    act_deal   = deal_edge;
    act_hit    = hit_edge & ~deal_edge;
    act_stand  = stand_edge & ~deal_edge & ~hit_edge;
  end

  // An ack only counts while a request is outstanding; it goes to the requested hand.
  always_comb begin
    ack_ok = req_q & card_ack;
    p_add  = ack_ok & ~to_dealer_q;
    d_add  = ack_ok &  to_dealer_q;
  end

  // Game sequencing: every draw is request, ack, then one evaluation cycle with the request low.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    req_d       = req_q;
    to_dealer_d = to_dealer_q;
    cnt_d       = cnt_q;
    hands_clear = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESULT: begin
        if (act_deal) begin
          state_d     = ST_DEAL;
          result_d    = RES_NONE;
          hands_clear = 1'b1;
          cnt_d       = 2'd0;
          req_d       = 1'b1;
          to_dealer_d = 1'b0;
        end
      end
      ST_DEAL: begin
        if (req_q) begin
          if (card_ack) begin
            req_d = 1'b0;
            cnt_d = cnt_q + 2'd1;
          end
        end else if (cnt_q == 2'd0) begin
          // Counter wrapped: all four opening cards are in.
          state_d = (p_total == LIMIT_T) ? ST_DEALER : ST_PLAYER;
        end else begin
          req_d       = 1'b1;
          to_dealer_d = cnt_q[0];
        end
      end
      ST_PLAYER: begin
        if (act_hit) begin
          state_d     = ST_DRAW_P;
          req_d       = 1'b1;
          to_dealer_d = 1'b0;
        end else if (act_stand) begin
          state_d = ST_DEALER;
        end
      end
      ST_DRAW_P: begin
        if (req_q) begin
          if (card_ack) begin
            req_d = 1'b0;
          end
        end else if (p_total > LIMIT_T) begin
          state_d  = ST_RESULT;
          result_d = RES_DEALER_WIN;
        end else if (p_total == LIMIT_T) begin
          state_d = ST_DEALER;
        end else begin
          state_d = ST_PLAYER;
        end
      end
      ST_DEALER: begin
        if (req_q) begin
          if (card_ack) begin
            req_d = 1'b0;
          end
        end else if (d_total < STAND_T) begin
          req_d       = 1'b1;
          to_dealer_d = 1'b1;
        end else begin
          state_d  = ST_RESULT;
          result_d = judge(p_total, d_total, LIMIT_T);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        result_d = RES_NONE;
        req_d    = 1'b0;
      end
    endcase
  end

  // Controller registers, cleared asynchronously even mid-handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q       <= '0;
      state_q     <= ST_IDLE;
      result_q    <= RES_NONE;
      req_q       <= 1'b0;
      to_dealer_q <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      btn_q       <= btn_d;
      state_q     <= state_d;
      result_q    <= result_d;
      req_q       <= req_d;
      to_dealer_q <= to_dealer_d;
      cnt_q       <= cnt_d;
    end
  end

  hand_acc u_player (
    .clk        (clk),
    .rst        (rst),
    .clear      (hands_clear),
    .add        (p_add),
    .card_value (card_value),
    .total      (p_total),
    .cards      (p_cards)
  );

  hand_acc u_dealer (
    .clk        (clk),
    .rst        (rst),
    .clear      (hands_clear),
    .add        (d_add),
    .card_value (card_value),
    .total      (d_total),
    .cards      (d_cards)
  );

  assign card_req       = req_q;
  assign card_to_dealer = to_dealer_q;
  assign state          = state_q;
  assign result         = result_q;
  assign player_total   = p_total;
  assign dealer_total   = d_total;
  assign player_cards   = p_cards;
  assign dealer_cards   = d_cards;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - scoreboard bench for game_ctrl with a modelled card source
module tb_game_ctrl;
  import blackjack_pkg::*;

  logic       clk, rst, deal, hit, stand;
  logic       card_req, card_ack, card_to_dealer;
  logic [3:0] card_value, player_cards, dealer_cards;
  logic [2:0] state;
  logic [4:0] player_total, dealer_total;
  logic [1:0] result;

  game_ctrl #(.DEALER_STAND(17), .BJ_LIMIT(21)) dut (
    .clk            (clk),
    .rst            (rst),
    .deal           (deal),
    .hit            (hit),
    .stand          (stand),
    .card_req       (card_req),
    .card_ack       (card_ack),
    .card_value     (card_value),
    .card_to_dealer (card_to_dealer),
    .state          (state),
    .player_total   (player_total),
    .dealer_total   (dealer_total),
    .player_cards   (player_cards),
    .dealer_cards   (dealer_cards),
    .result         (result)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [4:0] pt;
    logic [4:0] dt;
    logic [3:0] pc;
    logic [3:0] dc;
    logic [1:0] res;
  } snap_t;

  typedef struct packed {
    logic [3:0] val;
    logic       dest;
  } card_t;

  snap_t      exp_q[$];
  card_t      card_q[$];
  int         n_checks, n_fails;
  int         req_count, src_delay, force_cnt, force_done;
  logic       src_en;
  logic [3:0] force_val;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic expect_snap(input int st, input int pt, input int dt,
                             input int pc, input int dc, input int res);
    snap_t s;
    s.st  = 3'(st);
    s.pt  = 5'(pt);
    s.dt  = 5'(dt);
    s.pc  = 4'(pc);
    s.dc  = 4'(dc);
    s.res = 2'(res);
    exp_q.push_back(s);
  endtask

  task automatic give(input int v, input int d);
    card_t c;
    c.val  = 4'(v);
    c.dest = (d != 0);
    card_q.push_back(c);
  endtask

  task automatic press(input logic d, input logic h, input logic s);
    @(negedge clk);
    deal = d; hit = h; stand = s;
    @(negedge clk);
    deal = 1'b0; hit = 1'b0; stand = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || card_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_completed"}, int'(n < 3000), 1);
    repeat (20) @(negedge clk);
  endtask

  // Monitor: every state change is a DUT output event, checked against the queue head.
  initial begin : monitor
    logic [2:0] prev;
    snap_t      got, want;
    prev = 3'd0;
    forever begin
      @(negedge clk);
      if (state != prev) begin
        got = {state, player_total, dealer_total, player_cards, dealer_cards, result};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++;
          $display("FAIL unexpected_transition: got state %0d, expected no change from %0d", state, prev);
        end else begin
          want = exp_q.pop_front();
          if (got != want) begin
            n_fails++;
            $display("FAIL transition: got st=%0d pt=%0d dt=%0d pc=%0d dc=%0d res=%0d, expected st=%0d pt=%0d dt=%0d pc=%0d dc=%0d res=%0d",
                     got.st, got.pt, got.dt, got.pc, got.dc, got.res,
                     want.st, want.pt, want.dt, want.pc, want.dc, want.res);
          end
        end
        prev = state;
      end
    end
  end

  // Card source: acks queued cards after src_delay cycles of request, or injects a forced ack.
  initial begin : source
    logic  req_prev;
    int    dly;
    card_t e;
    req_prev   = 1'b0;
    dly        = 0;
    req_count  = 0;
    force_done = 0;
    card_ack   = 1'b0;
    card_value = 4'd0;
    forever begin
      @(negedge clk);
      if (card_req && !req_prev) req_count++;
      req_prev = card_req;
      if (card_ack) begin
        card_ack = 1'b0;
      end else if (force_cnt != force_done) begin
        card_ack   = 1'b1;
        card_value = force_val;
        force_done++;
      end else if (src_en && card_req && card_q.size() > 0) begin
        if (dly >= src_delay) begin
          e = card_q.pop_front();
          chk("card_destination", int'(card_to_dealer), int'(e.dest));
          card_ack   = 1'b1;
          card_value = e.val;
          dly        = 0;
        end else begin
          dly++;
        end
      end else begin
        dly = 0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d failures before abort", n_fails);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int r0;
    rst = 1'b1; deal = 1'b0; hit = 1'b0; stand = 1'b0;
    src_en = 1'b1; src_delay = 1; force_cnt = 0; force_val = 4'd0;
    n_checks = 0; n_fails = 0;

    repeat (3) @(negedge clk);
    chk("reset_state", state, ST_IDLE);
    chk("reset_card_req", card_req, 0);
    chk("reset_to_dealer", card_to_dealer, 0);
    chk("reset_player_total", player_total, 0);
    chk("reset_dealer_total", dealer_total, 0);
    chk("reset_player_cards", player_cards, 0);
    chk("reset_dealer_cards", dealer_cards, 0);
    chk("reset_result", result, RES_NONE);
    #1 rst = 1'b0;

    // Held deal: one deal only; player 10+7=17, dealer 5+9=14.
    r0 = req_count;
    give(10, 0); give(5, 1); give(7, 0); give(9, 1);
    expect_snap(ST_DEAL, 0, 0, 0, 0, RES_NONE);
    expect_snap(ST_PLAYER, 17, 14, 2, 2, RES_NONE);
    @(negedge clk);
    deal = 1'b1;
    @(negedge clk);
    chk("deal_latency_state", state, ST_DEAL);
    chk("deal_latency_req", card_req, 1);
    repeat (999) @(negedge clk);
    deal = 1'b0;
    chk("held_deal_requests", req_count - r0, 4);
    chk("held_deal_state", state, ST_PLAYER);
    chk("held_deal_pending", exp_q.size(), 0);
    // Ack with no request outstanding must not touch the hands.
    force_val = 4'd10;
    force_cnt++;
    repeat (5) @(negedge clk);
    chk("stray_ack_player", player_total, 17);
    chk("stray_ack_dealer", dealer_total, 14);
    // Stand on 17: dealer 14 draws 4 -> 18, dealer wins.
    give(4, 1);
    expect_snap(ST_DEALER, 17, 14, 2, 2, RES_NONE);
    expect_snap(ST_RESULT, 17, 18, 2, 3, RES_DEALER_WIN);
    press(1'b0, 1'b0, 1'b1);
    drain("stand_17");

    // Player 10+6 hits 9 -> 25 bust, no dealer draw.
    r0 = req_count;
    give(10, 0); give(5, 1); give(6, 0); give(9, 1);
    expect_snap(ST_DEAL, 0, 0, 0, 0, RES_NONE);
    expect_snap(ST_PLAYER, 16, 14, 2, 2, RES_NONE);
    press(1'b1, 1'b0, 1'b0);
    drain("bust_deal");
    give(9, 0);
    expect_snap(ST_DRAW_P, 16, 14, 2, 2, RES_NONE);
    expect_snap(ST_RESULT, 25, 14, 3, 2, RES_DEALER_WIN);
    press(1'b0, 1'b1, 1'b0);
    drain("bust_hit");
    chk("bust_requests", req_count - r0, 5);
    chk("bust_result", result, RES_DEALER_WIN);

    // Dealer ace+6 is soft 17 and stands; player 18 wins.
    r0 = req_count;
    give(10, 0); give(1, 1); give(8, 0); give(6, 1);
    expect_snap(ST_DEAL, 0, 0, 0, 0, RES_NONE);
    expect_snap(ST_PLAYER, 18, 17, 2, 2, RES_NONE);
    press(1'b1, 1'b0, 1'b0);
    drain("soft17_deal");
    expect_snap(ST_DEALER, 18, 17, 2, 2, RES_NONE);
    expect_snap(ST_RESULT, 18, 17, 2, 2, RES_PLAYER_WIN);
    press(1'b0, 1'b0, 1'b1);
    drain("soft17_stand");
    chk("soft17_requests", req_count - r0, 4);

    // Dealer ace+5=16 draws 10 -> hard 16, draws 3 -> 19; player 19 -> push.
    r0 = req_count;
    give(10, 0); give(1, 1); give(9, 0); give(5, 1);
    expect_snap(ST_DEAL, 0, 0, 0, 0, RES_NONE);
    expect_snap(ST_PLAYER, 19, 16, 2, 2, RES_NONE);
    press(1'b1, 1'b0, 1'b0);
    drain("soft16_deal");
    give(10, 1); give(3, 1);
    expect_snap(ST_DEALER, 19, 16, 2, 2, RES_NONE);
    expect_snap(ST_RESULT, 19, 19, 2, 4, RES_PUSH);
    press(1'b0, 1'b0, 1'b1);
    drain("soft16_stand");
    chk("soft16_requests", req_count - r0, 6);

    // Player ace + code 13 is 21: skip PLAYER; dealer 0-code(10)+6 draws 5 -> 21 push.
    r0 = req_count;
    give(1, 0); give(0, 1); give(13, 0); give(6, 1); give(5, 1);
    expect_snap(ST_DEAL, 0, 0, 0, 0, RES_NONE);
    expect_snap(ST_DEALER, 21, 16, 2, 2, RES_NONE);
    expect_snap(ST_RESULT, 21, 21, 2, 3, RES_PUSH);
    press(1'b1, 1'b0, 1'b0);
    drain("natural");
    chk("natural_requests", req_count - r0, 5);

    // Clicks during an outstanding request are dropped.
    give(10, 0); give(7, 1); give(2, 0); give(10, 1);
    expect_snap(ST_DEAL, 0, 0, 0, 0, RES_NONE);
    expect_snap(ST_PLAYER, 12, 17, 2, 2, RES_NONE);
    press(1'b1, 1'b0, 1'b0);
    drain("busy_deal");
    src_delay = 8;
    give(5, 0);
    expect_snap(ST_DRAW_P, 12, 17, 2, 2, RES_NONE);
    expect_snap(ST_PLAYER, 17, 17, 3, 2, RES_NONE);
    press(1'b0, 1'b1, 1'b0);
    chk("busy_req_outstanding", card_req, 1);
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b1, 1'b0);
    drain("busy_hit");
    src_delay = 1;
    chk("busy_player_cards", player_cards, 3);
    expect_snap(ST_DEALER, 17, 17, 3, 2, RES_NONE);
    expect_snap(ST_RESULT, 17, 17, 3, 2, RES_PUSH);
    press(1'b0, 1'b0, 1'b1);
    drain("busy_stand");
    // Deal and hit edges together in RESULT: only the deal acts.
    give(9, 0); give(9, 1); give(9, 0); give(9, 1);
    expect_snap(ST_DEAL, 0, 0, 0, 0, RES_NONE);
    expect_snap(ST_PLAYER, 18, 18, 2, 2, RES_NONE);
    press(1'b1, 1'b1, 1'b0);
    drain("deal_and_hit");

    // Reset while a request is outstanding and acked in the same cycle.
    src_en = 1'b0;
    expect_snap(ST_DRAW_P, 18, 18, 2, 2, RES_NONE);
    expect_snap(ST_IDLE, 0, 0, 0, 0, RES_NONE);
    press(1'b0, 1'b1, 1'b0);
    chk("midreset_req_before", card_req, 1);
    @(negedge clk);
    #2 force_val = 4'd5;
    force_cnt++;
    @(negedge clk);
    #1;
    chk("midreset_ack_present", card_ack, 1);
    rst = 1'b1;
    #1;
    chk("midreset_state", state, ST_IDLE);
    chk("midreset_card_req", card_req, 0);
    chk("midreset_to_dealer", card_to_dealer, 0);
    chk("midreset_player_total", player_total, 0);
    chk("midreset_dealer_total", dealer_total, 0);
    chk("midreset_player_cards", player_cards, 0);
    chk("midreset_dealer_cards", dealer_cards, 0);
    chk("midreset_result", result, RES_NONE);
    @(negedge clk);
    #1 rst = 1'b0;
    src_en = 1'b1;
    drain("midreset");

    // Clean restart: player 2+4=6, dealer 3+5=8, opening order from the first card.
    r0 = req_count;
    give(2, 0); give(3, 1); give(4, 0); give(5, 1);
    expect_snap(ST_DEAL, 0, 0, 0, 0, RES_NONE);
    expect_snap(ST_PLAYER, 6, 8, 2, 2, RES_NONE);
    press(1'b1, 1'b0, 1'b0);
    drain("restart");
    chk("restart_requests", req_count - r0, 4);

    chk("leftover_expectations", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
